// File: rtl/wb_pkg.sv
// Shared types for the write-back stage.
//   wb_sel_e  : register-file write source select
//   lsize_e   : load size used by the memory-data extender
//   q_state_e : occupancy of the write-back skid queue
//   WB_DEPTH  : number of queue entries
package wb_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_MEM   = 3'd1,
    WB_LUI   = 3'd2,
    WB_ZERO  = 3'd3,
    WB_ONE   = 3'd4,
    WB_SHIFT = 3'd5,
    WB_LINK  = 3'd6,
    WB_RSVD  = 3'd7
  } wb_sel_e;

  typedef enum logic [1:0] {
    LS_WORD = 2'd0,
    LS_HALF = 2'd1,
    LS_BYTE = 2'd2
  } lsize_e;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

  localparam int unsigned WB_DEPTH = 2;

endpackage

// File: rtl/load_extend.sv
// Memory-data lane select and sign/zero extension (combinational).
//   i_mdr     : raw memory data word
//   i_lsize   : WORD / HALF / BYTE
//   i_lsigned : sign-extend sub-word results when set
//   i_boff    : byte offset of the load address
//   o_data    : aligned, extended result
module load_extend
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BOFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_mdr,
  input  lsize_e            i_lsize,
  input  logic              i_lsigned,
  input  logic [BOFF_W-1:0] i_boff,
  output logic [DATA_W-1:0] o_data
);

  logic [BOFF_W-1:0] w_hidx;
  logic [BOFF_W+3:0] w_hshamt;
  logic [BOFF_W+2:0] w_bshamt;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;

  // Halfword lanes ignore the low offset bit.
  assign w_hidx   = i_boff >> 1;
  assign w_hshamt = {w_hidx, 4'b0000};
  assign w_bshamt = {i_boff, 3'b000};
  assign w_half   = 16'(i_mdr >> w_hshamt);
  assign w_byte   = 8'(i_mdr >> w_bshamt);

  always_comb begin
    o_data = i_mdr;
    case (i_lsize)
      LS_HALF: o_data = {{(DATA_W-16){i_lsigned & w_half[15]}}, w_half};
      LS_BYTE: o_data = {{(DATA_W-8){i_lsigned & w_byte[7]}}, w_byte};
      default: o_data = i_mdr;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: source mux, 2-entry skid queue toward the register
// file, and forwarding lookup over queued entries.
//   clk, reset (async, active-low)
//   in_valid/in_ready, in_sel, in_rd, in_alu/mdr/lui/shift/link,
//   in_lsize, in_lsigned, in_boff  : write-back request
//   wb_valid/wb_ready, wb_rd, wb_data : register-file write port
//   fwd_rs/fwd_rt -> fwd_*_hit, fwd_*_data : youngest pending match
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned BOFF_W  = $clog2(DATA_W / 8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  wb_sel_e            in_sel,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_mdr,
  input  logic [DATA_W-1:0]  in_lui,
  input  logic [DATA_W-1:0]  in_shift,
  input  logic [DATA_W-1:0]  in_link,
  input  lsize_e             in_lsize,
  input  logic               in_lsigned,
  input  logic [BOFF_W-1:0]  in_boff,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  input  logic [RADDR_W-1:0] fwd_rs,
  input  logic [RADDR_W-1:0] fwd_rt,
  output logic               fwd_rs_hit,
  output logic               fwd_rt_hit,
  output logic [DATA_W-1:0]  fwd_rs_data,
  output logic [DATA_W-1:0]  fwd_rt_data
);

  q_state_e            r_state;
  q_state_e            w_state_next;
  logic                r_head;
  logic                r_tail;
  logic [RADDR_W-1:0]  r_rd   [WB_DEPTH];
  logic [DATA_W-1:0]   r_data [WB_DEPTH];

  logic [DATA_W-1:0]   w_mem;
  logic [DATA_W-1:0]   w_src;
  logic                w_push;
  logic                w_pop;
  logic                w_young;

  load_extend #(
    .DATA_W (DATA_W),
    .BOFF_W (BOFF_W)
  ) u_load_extend (
    .i_mdr     (in_mdr),
    .i_lsize   (in_lsize),
    .i_lsigned (in_lsigned),
    .i_boff    (in_boff),
    .o_data    (w_mem)
  );

  always_comb begin
    w_src = in_alu;
    case (in_sel)
      WB_MEM:   w_src = w_mem;
      WB_LUI:   w_src = in_lui;
      WB_ZERO:  w_src = '0;
      WB_ONE:   w_src = {{(DATA_W-1){1'b0}}, 1'b1};
      WB_SHIFT: w_src = in_shift;
      WB_LINK:  w_src = in_link;
      default:  w_src = in_alu;
    endcase
  end

  assign in_ready = (r_state != Q_FULL);
  assign wb_valid = (r_state != Q_EMPTY);
  // Writes to register zero are acknowledged but never enqueued.
  assign w_push   = in_valid && in_ready && (in_rd != '0);
  assign w_pop    = wb_valid && wb_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= Q_EMPTY;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      Q_EMPTY: if (w_push) w_state_next = Q_ONE;
      Q_ONE: begin
        if (w_push && !w_pop)      w_state_next = Q_FULL;
        else if (w_pop && !w_push) w_state_next = Q_EMPTY;
      end
      Q_FULL:  if (w_pop) w_state_next = Q_ONE;
      default: w_state_next = Q_EMPTY;
    endcase
  end

  // Push writes the tail slot; pop advances the head. A simultaneous
  // push/pop in ONE therefore makes the new entry the head.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head <= 1'b0;
      r_tail <= 1'b0;
      for (int unsigned i = 0; i < WB_DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_rd[r_tail]   <= in_rd;
        r_data[r_tail] <= w_src;
        r_tail         <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
    end
  end

  assign wb_rd   = r_rd[r_head];
  assign wb_data = r_data[r_head];

  // Youngest entry sits just behind the tail pointer; in ONE it is the head.
  assign w_young = ~r_tail;

  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [RADDR_W-1:0] addr,
    input q_state_e           st,
    input logic               old_slot,
    input logic               yng_slot,
    input logic [RADDR_W-1:0] rd0,
    input logic [RADDR_W-1:0] rd1,
    input logic [DATA_W-1:0]  d0,
    input logic [DATA_W-1:0]  d1
  );
    logic [DATA_W:0] res;
    res = '0;
    if (addr != '0) begin
      if (st == Q_FULL && (old_slot ? rd1 : rd0) == addr)
        res = {1'b1, (old_slot ? d1 : d0)};
      if (st != Q_EMPTY && (yng_slot ? rd1 : rd0) == addr)
        res = {1'b1, (yng_slot ? d1 : d0)};
    end
    return res;
  endfunction

  always_comb begin
    {fwd_rs_hit, fwd_rs_data} = fwd_lookup(fwd_rs, r_state, r_head, w_young,
                                           r_rd[0], r_rd[1], r_data[0], r_data[1]);
    {fwd_rt_hit, fwd_rt_data} = fwd_lookup(fwd_rt, r_state, r_head, w_young,
                                           r_rd[0], r_rd[1], r_data[0], r_data[1]);
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned BOFF_W  = 2;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  wb_sel_e            in_sel;
  logic [RADDR_W-1:0] in_rd;
  logic [DATA_W-1:0]  in_alu, in_mdr, in_lui, in_shift, in_link;
  lsize_e             in_lsize;
  logic               in_lsigned;
  logic [BOFF_W-1:0]  in_boff;
  logic               wb_valid;
  logic               wb_ready;
  logic [RADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]  wb_data;
  logic [RADDR_W-1:0] fwd_rs, fwd_rt;
  logic               fwd_rs_hit, fwd_rt_hit;
  logic [DATA_W-1:0]  fwd_rs_data, fwd_rt_data;

  int unsigned n_checks;
  int unsigned n_fail;

  writeback_unit #(
    .DATA_W  (DATA_W),
    .RADDR_W (RADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sel      (in_sel),
    .in_rd       (in_rd),
    .in_alu      (in_alu),
    .in_mdr      (in_mdr),
    .in_lui      (in_lui),
    .in_shift    (in_shift),
    .in_link     (in_link),
    .in_lsize    (in_lsize),
    .in_lsigned  (in_lsigned),
    .in_boff     (in_boff),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .fwd_rs      (fwd_rs),
    .fwd_rt      (fwd_rt),
    .fwd_rs_hit  (fwd_rs_hit),
    .fwd_rt_hit  (fwd_rt_hit),
    .fwd_rs_data (fwd_rs_data),
    .fwd_rt_data (fwd_rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single request with wb_ready high: check head value, then drain.
  task automatic one_shot(input string tag, input wb_sel_e sel, input lsize_e ls,
                          input logic sgn, input logic [BOFF_W-1:0] boff,
                          input logic [DATA_W-1:0] exp);
    in_sel = sel; in_lsize = ls; in_lsigned = sgn; in_boff = boff;
    in_rd = 5'd9; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    check_eq(tag, {32'd0, wb_data}, {32'd0, exp});
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b0; in_valid = 1'b0; in_sel = WB_ALU; in_rd = '0;
    in_alu = '0; in_mdr = '0; in_lui = '0; in_shift = '0; in_link = '0;
    in_lsize = LS_WORD; in_lsigned = 1'b0; in_boff = '0;
    wb_ready = 1'b1; fwd_rs = '0; fwd_rt = '0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("rst_wb_rd",    {59'd0, wb_rd}, 64'd0);
    check_eq("rst_wb_data",  {32'd0, wb_data}, 64'd0);
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    fwd_rs = 5'd5; fwd_rt = 5'd1; #1;
    check_eq("rst_fwd_hits", {62'd0, fwd_rs_hit, fwd_rt_hit}, 64'd0);
    check_eq("rst_fwd_data", {fwd_rs_data, fwd_rt_data}, 64'd0);

    // Single accept, one-cycle latency, drain.
    in_sel = WB_ALU; in_alu = 32'h0000_1234; in_rd = 5'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; #1;
    check_eq("first_valid", {63'd0, wb_valid}, 64'd1);
    check_eq("first_rd",    {59'd0, wb_rd}, 64'd5);
    check_eq("first_data",  {32'd0, wb_data}, 64'h1234);
    check_eq("first_fwd",   {31'd0, fwd_rs_hit, fwd_rs_data}, {31'd0, 1'b1, 32'h1234});
    tick();
    check_eq("first_drained", {63'd0, wb_valid}, 64'd0);

    // Source select and load extension.
    in_mdr = 32'h80FF_7F81; in_lui = 32'h1234_0000; in_shift = 32'h0000_0F0F;
    in_link = 32'h0000_4008; in_alu = 32'hCAFE_0001;
    one_shot("byte_s_b0", WB_MEM, LS_BYTE, 1'b1, 2'd0, 32'hFFFF_FF81);
    one_shot("byte_u_b3", WB_MEM, LS_BYTE, 1'b0, 2'd3, 32'h0000_0080);
    one_shot("byte_s_b1", WB_MEM, LS_BYTE, 1'b1, 2'd1, 32'h0000_007F);
    one_shot("half_s_b2", WB_MEM, LS_HALF, 1'b1, 2'd2, 32'hFFFF_80FF);
    one_shot("half_s_b3", WB_MEM, LS_HALF, 1'b1, 2'd3, 32'hFFFF_80FF);
    one_shot("half_u_b0", WB_MEM, LS_HALF, 1'b0, 2'd0, 32'h0000_7F81);
    one_shot("word",      WB_MEM, LS_WORD, 1'b1, 2'd2, 32'h80FF_7F81);
    one_shot("sel_lui",   WB_LUI,   LS_WORD, 1'b0, 2'd0, 32'h1234_0000);
    one_shot("sel_zero",  WB_ZERO,  LS_WORD, 1'b0, 2'd0, 32'h0000_0000);
    one_shot("sel_one",   WB_ONE,   LS_WORD, 1'b0, 2'd0, 32'h0000_0001);
    one_shot("sel_shift", WB_SHIFT, LS_WORD, 1'b0, 2'd0, 32'h0000_0F0F);
    one_shot("sel_link",  WB_LINK,  LS_WORD, 1'b0, 2'd0, 32'h0000_4008);
    one_shot("sel_rsvd",  WB_RSVD,  LS_WORD, 1'b0, 2'd0, 32'hCAFE_0001);

    // Back-pressure: two absorbed, third stalls, drain in order.
    wb_ready = 1'b0; in_sel = WB_ALU;
    in_alu = 32'hA1; in_rd = 5'd1; in_valid = 1'b1;
    tick();
    check_eq("bp_ready_after1", {63'd0, in_ready}, 64'd1);
    in_alu = 32'hB2; in_rd = 5'd2;
    tick();
    check_eq("bp_ready_after2", {63'd0, in_ready}, 64'd0);
    in_alu = 32'hC3; in_rd = 5'd3;
    tick();
    check_eq("bp_stall_ready", {63'd0, in_ready}, 64'd0);
    check_eq("bp_hold_head", {27'd0, wb_rd, wb_data}, {27'd0, 5'd1, 32'hA1});
    fwd_rs = 5'd1; fwd_rt = 5'd2; #1;
    check_eq("bp_fwd_rs", {31'd0, fwd_rs_hit, fwd_rs_data}, {31'd0, 1'b1, 32'hA1});
    check_eq("bp_fwd_rt", {31'd0, fwd_rt_hit, fwd_rt_data}, {31'd0, 1'b1, 32'hB2});
    wb_ready = 1'b1; #1;
    check_eq("bp_no_comb_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check_eq("bp_ready_recover", {63'd0, in_ready}, 64'd1);
    check_eq("bp_drain2", {27'd0, wb_rd, wb_data}, {27'd0, 5'd2, 32'hB2});
    tick();
    in_valid = 1'b0; #1;
    check_eq("bp_third", {26'd0, wb_valid, wb_rd, wb_data}, {26'd0, 1'b1, 5'd3, 32'hC3});
    tick();
    check_eq("bp_empty", {63'd0, wb_valid}, 64'd0);

    // Register zero is acknowledged but discarded.
    wb_ready = 1'b0; in_sel = WB_ONE; in_rd = 5'd0; in_valid = 1'b1; #1;
    check_eq("r0_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0; fwd_rs = 5'd0; #1;
    check_eq("r0_no_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("r0_no_fwd", {63'd0, fwd_rs_hit}, 64'd0);

    // Two pending writes to the same register: younger wins.
    in_sel = WB_ALU; in_rd = 5'd7; in_alu = 32'h11; in_valid = 1'b1;
    tick();
    in_alu = 32'h22;
    tick();
    in_valid = 1'b0; fwd_rs = 5'd7; fwd_rt = 5'd9; #1;
    check_eq("fwd_young", {31'd0, fwd_rs_hit, fwd_rs_data}, {31'd0, 1'b1, 32'h22});
    check_eq("fwd_miss",  {31'd0, fwd_rt_hit, fwd_rt_data}, 64'd0);
    check_eq("fwd_head",  {27'd0, wb_rd, wb_data}, {27'd0, 5'd7, 32'h11});

    // Asynchronous reset while FULL.
    #2 reset = 1'b0; #1;
    check_eq("arst_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("arst_ready", {63'd0, in_ready}, 64'd1);
    check_eq("arst_fwd",   {63'd0, fwd_rs_hit}, 64'd0);
    @(negedge clk);
    reset = 1'b1; wb_ready = 1'b1;
    tick();
    check_eq("arst_no_stale0", {63'd0, wb_valid}, 64'd0);
    tick();
    check_eq("arst_no_stale1", {63'd0, wb_valid}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
